// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_if
// Purpose  : Handshake bundle for one pipeline stage: upstream valid/ready
//            word, flush, downstream valid/ready word, stall counter.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Registered pipeline stage with head + skid storage; in_ready is
//            a pure state decode so no ready path crosses the stage.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 32,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipe_stage_skid_if.slave  bus
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CTRL_W-1:0] r_head_ctrl;
    logic [DATA_W-1:0] r_head_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_in_ready;
    logic w_out_valid;
    logic w_accept;
    logic w_issue;
    logic w_load_head_in;
    logic w_load_head_skid;
    logic w_load_skid;

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_issue  = w_out_valid & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and payload load decode; flush suppresses every load so a
    // killed word never reaches the head register.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = S_ONE;
                        w_load_head_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_issue) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_issue && !w_accept) begin
                        w_state_nxt = S_EMPTY;
                    end else if (w_issue && w_accept) begin
                        w_load_head_in = 1'b1;
                    end
                end
                S_TWO: begin
                    if (w_issue) begin
                        w_state_nxt      = S_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output decode from state only
    always_comb begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
            S_ONE: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b1;
            end
            S_TWO: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_ctrl <= '0;
            r_head_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head_ctrl <= bus.in_ctrl;
                r_head_data <= bus.in_data;
            end else if (w_load_head_skid) begin
                r_head_ctrl <= r_skid_ctrl;
                r_head_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= bus.in_ctrl;
                r_skid_data <= bus.in_data;
            end
        end
    end

    // Back-pressure counter saturates and deliberately ignores flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_ctrl  = w_out_valid ? r_head_ctrl : NOP_CTRL;
    assign bus.out_data  = r_head_data;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Directed and random self-checking bench for pipe_stage_skid.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam logic [31:0] C_NOP = 32'h0000_BEEF;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(32), .CNT_W(16)) bm ();
    pipe_stage_skid_if #(.DATA_W(8),  .CTRL_W(4),  .CNT_W(2))  bs ();

    pipe_stage_skid #(
        .DATA_W(64), .CTRL_W(32), .NOP_CTRL(C_NOP), .CNT_W(16)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bm.slave)
    );

    pipe_stage_skid #(
        .DATA_W(8), .CTRL_W(4), .NOP_CTRL(4'h0), .CNT_W(2)
    ) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bm.in_valid = 1'b0; bm.in_ctrl = '0; bm.in_data = '0;
        bm.flush = 1'b0; bm.out_ready = 1'b0;
        bs.in_valid = 1'b0; bs.in_ctrl = '0; bs.in_data = '0;
        bs.flush = 1'b0; bs.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bm.in_valid = 1'b1; bm.in_data = 64'h77; bm.in_ctrl = 32'h7;
        #2;
        total++;
        if (bm.in_ready !== 1'b1 || bm.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs got=%b%b exp=10", bm.in_ready, bm.out_valid);
        end
        total++;
        if (bm.out_ctrl !== C_NOP || bm.out_data !== 64'h0 || bm.stall_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_vals got=%h/%h/%h exp=%h/0/0", bm.out_ctrl, bm.out_data, bm.stall_cnt, C_NOP);
        end
        step();
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bs.out_valid !== 1'b0 || bs.stall_cnt !== 2'd0) begin
            bad++; $display("FAIL reset_held got=%b%b exp=00", bm.out_valid, bs.out_valid);
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release got=%b%b exp=01", bm.out_valid, bm.in_ready);
        end
    endtask

    task automatic test_stream();
        logic ok;
        do_reset();
        ok = 1'b1;
        bm.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bm.in_valid = 1'b1;
            bm.in_data  = 64'(i);
            bm.in_ctrl  = 32'(100 + i);
            step();
            total++;
            if (bm.out_valid !== 1'b1 || bm.out_data !== 64'(i) ||
                bm.out_ctrl !== 32'(100 + i) || bm.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d got=v%b d%0h c%0h r%b exp=v1 d%0h c%0h r1",
                         i, bm.out_valid, bm.out_data, bm.out_ctrl, bm.in_ready, i, 100 + i);
            end
        end
        bm.in_valid = 1'b0;
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.out_ctrl !== C_NOP || bm.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL stream_drain got=v%b c%h s%0d exp=v0 c%h s0", bm.out_valid, bm.out_ctrl, bm.stall_cnt, C_NOP);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bm.out_ready = 1'b0;
        bm.in_valid = 1'b1; bm.in_data = 64'h11; bm.in_ctrl = 32'hA1;
        step();
        total++;
        if (bm.out_valid !== 1'b1 || bm.out_data !== 64'h11 || bm.stall_cnt !== 16'd0) begin
            bad++; $display("FAIL bp_one got=v%b d%h s%0d exp=v1 d11 s0", bm.out_valid, bm.out_data, bm.stall_cnt);
        end
        bm.in_data = 64'h22; bm.in_ctrl = 32'hA2;
        step();
        total++;
        if (bm.in_ready !== 1'b0 || bm.out_data !== 64'h11 || bm.stall_cnt !== 16'd1) begin
            bad++; $display("FAIL bp_two got=r%b d%h s%0d exp=r0 d11 s1", bm.in_ready, bm.out_data, bm.stall_cnt);
        end
        bm.in_data = 64'h99;
        step();
        total++;
        if (bm.in_ready !== 1'b0 || bm.out_data !== 64'h11 || bm.stall_cnt !== 16'd2) begin
            bad++; $display("FAIL bp_hold got=r%b d%h s%0d exp=r0 d11 s2", bm.in_ready, bm.out_data, bm.stall_cnt);
        end
        bm.in_valid = 1'b0;
        bm.out_ready = 1'b1;
        step();
        total++;
        if (bm.out_valid !== 1'b1 || bm.out_data !== 64'h22 || bm.out_ctrl !== 32'hA2 ||
            bm.in_ready !== 1'b1 || bm.stall_cnt !== 16'd2) begin
            bad++; $display("FAIL bp_issue1 got=v%b d%h r%b s%0d exp=v1 d22 r1 s2", bm.out_valid, bm.out_data, bm.in_ready, bm.stall_cnt);
        end
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.out_ctrl !== C_NOP) begin
            bad++; $display("FAIL bp_issue2 got=v%b c%h exp=v0 c%h", bm.out_valid, bm.out_ctrl, C_NOP);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bm.out_ready = 1'b0;
        bm.in_valid = 1'b1; bm.in_data = 64'h11; bm.in_ctrl = 32'hB1;
        step();
        bm.in_data = 64'h22; bm.in_ctrl = 32'hB2;
        step();
        bm.in_data = 64'h33; bm.in_ctrl = 32'hB3;
        bm.flush = 1'b1;
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.out_ctrl !== C_NOP || bm.in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_two got=v%b c%h r%b exp=v0 c%h r1", bm.out_valid, bm.out_ctrl, bm.in_ready, C_NOP);
        end
        total++;
        if (bm.out_data !== 64'h11 || bm.stall_cnt !== 16'd2) begin
            bad++; $display("FAIL flush_keep got=d%h s%0d exp=d11 s2", bm.out_data, bm.stall_cnt);
        end
        bm.flush = 1'b0;
        bm.in_valid = 1'b0;
        bm.out_ready = 1'b1;
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.out_data === 64'h33) begin
            bad++; $display("FAIL flush_gone got=v%b d%h exp=v0 not33", bm.out_valid, bm.out_data);
        end
        bm.in_valid = 1'b1; bm.in_data = 64'h44; bm.in_ctrl = 32'hB4;
        step();
        bm.in_valid = 1'b0;
        total++;
        if (bm.out_valid !== 1'b1 || bm.out_data !== 64'h44 || bm.out_ctrl !== 32'hB4) begin
            bad++; $display("FAIL flush_after got=v%b d%h exp=v1 d44", bm.out_valid, bm.out_data);
        end
        step();
    endtask

    task automatic test_saturation();
        int sat_exp [6];
        sat_exp = '{1, 2, 3, 3, 3, 3};
        do_reset();
        bs.out_ready = 1'b0;
        bs.in_valid = 1'b1; bs.in_data = 8'hA5; bs.in_ctrl = 4'h5;
        step();
        bs.in_valid = 1'b0;
        total++;
        if (bs.out_valid !== 1'b1 || bs.stall_cnt !== 2'd0) begin
            bad++; $display("FAIL sat_start got=v%b s%0d exp=v1 s0", bs.out_valid, bs.stall_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (bs.stall_cnt !== 2'(sat_exp[k])) begin
                bad++; $display("FAIL sat_%0d got=%0d exp=%0d", k, bs.stall_cnt, sat_exp[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bm.out_ready = 1'b0;
        bm.in_valid = 1'b1; bm.in_data = 64'h55; bm.in_ctrl = 32'hC5;
        step();
        bm.in_valid = 1'b0;
        step();
        step();
        total++;
        if (bm.out_valid !== 1'b1 || bm.stall_cnt !== 16'd2) begin
            bad++; $display("FAIL arst_pre got=v%b s%0d exp=v1 s2", bm.out_valid, bm.stall_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b1 || bm.stall_cnt !== 16'd0 ||
            bm.out_ctrl !== C_NOP || bm.out_data !== 64'h0) begin
            bad++; $display("FAIL arst_now got=v%b r%b s%0d d%h exp=v0 r1 s0 d0", bm.out_valid, bm.in_ready, bm.stall_cnt, bm.out_data);
        end
        #2;
        rst_n = 1'b1;
        step();
        total++;
        if (bm.out_valid !== 1'b0 || bm.in_ready !== 1'b1) begin
            bad++; $display("FAIL arst_after got=v%b r%b exp=v0 r1", bm.out_valid, bm.in_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] qd [$];
        logic [31:0] qc [$];
        int          exp_stall;
        logic        m_ready;
        logic        m_valid;
        do_reset();
        exp_stall = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bm.in_valid  = ($urandom_range(0, 9) < 6);
            bm.out_ready = ($urandom_range(0, 9) < 6);
            bm.flush     = ($urandom_range(0, 19) == 0);
            bm.in_data   = {$urandom, $urandom};
            bm.in_ctrl   = $urandom;
            #1;
            m_ready = (qd.size() < 2);
            m_valid = (qd.size() > 0);
            total++;
            if (bm.in_ready !== m_ready || bm.out_valid !== m_valid ||
                bm.stall_cnt !== 16'(exp_stall)) begin
                bad++;
                $display("FAIL rand_hs_%0d got=r%b v%b s%0d exp=r%b v%b s%0d",
                         cyc, bm.in_ready, bm.out_valid, bm.stall_cnt, m_ready, m_valid, exp_stall);
            end
            if (m_valid) begin
                total++;
                if (bm.out_data !== qd[0] || bm.out_ctrl !== qc[0]) begin
                    bad++;
                    $display("FAIL rand_data_%0d got=%h/%h exp=%h/%h", cyc, bm.out_data, bm.out_ctrl, qd[0], qc[0]);
                end
            end else begin
                total++;
                if (bm.out_ctrl !== C_NOP) begin
                    bad++; $display("FAIL rand_nop_%0d got=%h exp=%h", cyc, bm.out_ctrl, C_NOP);
                end
            end
            bm.out_ready = ~bm.out_ready;
            #1;
            total++;
            if (bm.in_ready !== m_ready) begin
                bad++; $display("FAIL rand_comb_%0d got=%b exp=%b", cyc, bm.in_ready, m_ready);
            end
            bm.out_ready = ~bm.out_ready;
            @(posedge clk);
            if (m_valid && !bm.out_ready && exp_stall < 65535) exp_stall++;
            if (bm.flush) begin
                qd.delete();
                qc.delete();
            end else begin
                if (m_valid && bm.out_ready) begin
                    void'(qd.pop_front());
                    void'(qc.pop_front());
                end
                if (bm.in_valid && m_ready) begin
                    qd.push_back(bm.in_data);
                    qc.push_back(bm.in_ctrl);
                end
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
